// File: rtl/jtag_master_pkg.sv
// Shared state type and TMS sequences for the jtag_master scan engine.
package jtag_master_pkg;

    typedef enum logic [2:0] {
        TLR_WALK,
        IDLE,
        PRE,
        SHIFT,
        POST
    } state_e;

    // TMS sequences are emitted LSB first, one bit per TCK period.
    localparam logic [2:0] PREFIX_DR   = 3'b001;
    localparam logic [3:0] PREFIX_IR   = 4'b0011;
    localparam logic [1:0] POST_TMS    = 2'b01;
    localparam logic [5:0] TLR_PERIODS = 6'd6;

    function automatic logic prefix_tms(input logic is_ir, input logic [1:0] idx);
        logic [3:0] seq;
        seq = is_ir ? PREFIX_IR : {1'b0, PREFIX_DR};
        return seq[idx];
    endfunction

    function automatic logic [5:0] prefix_last(input logic is_ir);
        return is_ir ? 6'd3 : 6'd2;
    endfunction

endpackage

// File: rtl/jtag_master_tckgen.sv
// TCK phase generator: one TCK period is 2*CLK_DIV clock cycles, low half first.
module jtag_master_tckgen
    import jtag_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    output logic tck_o,
    output logic fall_o,
    output logic rise_o
);

    localparam int unsigned PW = $clog2(2 * CLK_DIV);
    localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV);

    logic [PW-1:0] phase_q, phase_d;
    logic          tck_q, tck_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        phase_d = '0;
        tck_d   = 1'b0;
        if (enable_i) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
            tck_d   = (phase_d >= PH_RISE);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            tck_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            tck_q   <= tck_d;
        end
    end

    assign tck_o  = tck_q;
    // fall_o marks the last cycle of a period: TCK drops at the coming edge.
    assign fall_o = enable_i && (phase_q == PH_LAST);
    assign rise_o = enable_i && (phase_q == PH_RISE);

endmodule

// File: rtl/jtag_master.sv
// Bit-serial JTAG initiator: IR/DR scans of 1-32 bits, Run-Test/Idle to Run-Test/Idle.
module jtag_master
    import jtag_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        io_mainClk,
    input  logic        io_reset,
    input  logic        io_cmd_valid,
    output logic        io_cmd_ready,
    input  logic        io_cmd_isIr,
    input  logic [4:0]  io_cmd_length,
    input  logic [31:0] io_cmd_data,
    output logic        io_rsp_valid,
    output logic [31:0] io_rsp_data,
    output logic        io_jtag_tck,
    output logic        io_jtag_tms,
    output logic        io_jtag_tdi,
    input  logic        io_jtag_tdo
);

    state_e      state_q, state_d;
    logic [5:0]  period_q, period_d;
    logic        is_ir_q, is_ir_d;
    logic [4:0]  len_q, len_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] rsp_q, rsp_d;
    logic        tms_q, tms_d;
    logic        tdi_q, tdi_d;

    logic        fall;
    logic        rise;
    logic        accept;
    logic [5:0]  bit_count;

    jtag_master_tckgen #(
        .CLK_DIV (CLK_DIV)
    ) u_tckgen (
        .clk      (io_mainClk),
        .rst      (io_reset),
        .enable_i (state_q != IDLE),
        .tck_o    (io_jtag_tck),
        .fall_o   (fall),
        .rise_o   (rise)
    );

    assign bit_count    = {1'b0, len_q} + 6'd1;
    // The response cycle is the last cycle of the final POST period, so a new
    // command taken here starts PRE without an idle TCK period.
    assign io_rsp_valid = (state_q == POST) && (period_q == 6'd1) && fall;
    assign io_cmd_ready = (state_q == IDLE) || io_rsp_valid;
    assign accept       = io_cmd_valid && io_cmd_ready;

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        is_ir_d  = is_ir_q;
        len_d    = len_q;
        shift_d  = shift_q;
        rsp_d    = rsp_q;
        tms_d    = tms_q;
        tdi_d    = tdi_q;

        if (rise && (state_q == SHIFT)) begin
            rsp_d[period_q[4:0]] = io_jtag_tdo;
        end

        if (fall) begin
            period_d = period_q + 6'd1;
            unique case (state_q)
                TLR_WALK: begin
                    if (period_q == TLR_PERIODS - 6'd1) begin
                        state_d  = IDLE;
                        period_d = '0;
                        tms_d    = 1'b0;
                    end else begin
                        tms_d = (period_d < TLR_PERIODS - 6'd1);
                    end
                end
                PRE: begin
                    if (period_q == prefix_last(is_ir_q)) begin
                        state_d  = SHIFT;
                        period_d = '0;
                        tms_d    = (bit_count == 6'd1);
                        tdi_d    = shift_q[0];
                        shift_d  = shift_q >> 1;
                    end else begin
                        tms_d = prefix_tms(is_ir_q, period_d[1:0]);
                    end
                end
                SHIFT: begin
                    if (period_d == bit_count) begin
                        state_d  = POST;
                        period_d = '0;
                        tms_d    = POST_TMS[0];
                        tdi_d    = 1'b0;
                    end else begin
                        tms_d   = (period_d == bit_count - 6'd1);
                        tdi_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
                POST: begin
                    if (period_q == 6'd1) begin
                        state_d  = IDLE;
                        period_d = '0;
                        tms_d    = 1'b0;
                    end else begin
                        tms_d = POST_TMS[1];
                    end
                end
                default: begin
                    period_d = period_q;
                end
            endcase
        end

        if (accept) begin
            state_d  = PRE;
            period_d = '0;
            is_ir_d  = io_cmd_isIr;
            len_d    = io_cmd_length;
            shift_d  = io_cmd_data;
            rsp_d    = '0;
            tms_d    = prefix_tms(io_cmd_isIr, 2'd0);
            tdi_d    = 1'b0;
        end
    end

    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            state_q  <= TLR_WALK;
            period_q <= '0;
            is_ir_q  <= 1'b0;
            len_q    <= '0;
            shift_q  <= '0;
            rsp_q    <= '0;
            tms_q    <= 1'b1;
            tdi_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            is_ir_q  <= is_ir_d;
            len_q    <= len_d;
            shift_q  <= shift_d;
            rsp_q    <= rsp_d;
            tms_q    <= tms_d;
            tdi_q    <= tdi_d;
        end
    end

    assign io_rsp_data = rsp_q;
    assign io_jtag_tms = tms_q;
    assign io_jtag_tdi = tdi_q;

endmodule

// File: tb/tb_jtag_master.sv
// Directed bench for jtag_master driving a behavioural TAP with IDCODE and a 32-bit user register.
module tb_jtag_master;

    localparam int unsigned CLK_DIV = 2;
    localparam logic [31:0] IDCODE_VAL = 32'h10001FFF;
    localparam logic [3:0]  IR_IDCODE  = 4'h1;
    localparam logic [3:0]  IR_USER    = 4'h2;

    logic        clk = 1'b0;
    logic        io_reset = 1'b1;
    logic        io_cmd_valid = 1'b0;
    logic        io_cmd_ready;
    logic        io_cmd_isIr = 1'b0;
    logic [4:0]  io_cmd_length = '0;
    logic [31:0] io_cmd_data = '0;
    logic        io_rsp_valid;
    logic [31:0] io_rsp_data;
    logic        io_jtag_tck;
    logic        io_jtag_tms;
    logic        io_jtag_tdi;
    logic        io_jtag_tdo;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    jtag_master #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .io_mainClk    (clk),
        .io_reset      (io_reset),
        .io_cmd_valid  (io_cmd_valid),
        .io_cmd_ready  (io_cmd_ready),
        .io_cmd_isIr   (io_cmd_isIr),
        .io_cmd_length (io_cmd_length),
        .io_cmd_data   (io_cmd_data),
        .io_rsp_valid  (io_rsp_valid),
        .io_rsp_data   (io_rsp_data),
        .io_jtag_tck   (io_jtag_tck),
        .io_jtag_tms   (io_jtag_tms),
        .io_jtag_tdi   (io_jtag_tdi),
        .io_jtag_tdo   (io_jtag_tdo)
    );

    // ---------------- behavioural TAP target ----------------
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_e;

    tap_e        tap = TLR;
    logic [3:0]  ir = IR_IDCODE;
    logic [3:0]  ir_sr = '0;
    logic [31:0] dr_sr = '0;
    logic [31:0] user_q = 32'h3;
    logic [31:0] shift_in = '0;
    int          shift_cnt = 0;
    int          tlr_hits = 0;
    logic        tdo_r = 1'b0;
    bit          tms_log[$];

    assign io_jtag_tdo = tdo_r;

    function automatic tap_e tap_next(input tap_e s, input logic tms);
        case (s)
            TLR:    return tms ? TLR    : RTI;
            RTI:    return tms ? SEL_DR : RTI;
            SEL_DR: return tms ? SEL_IR : CAP_DR;
            CAP_DR: return tms ? EX1_DR : SH_DR;
            SH_DR:  return tms ? EX1_DR : SH_DR;
            EX1_DR: return tms ? UPD_DR : PAU_DR;
            PAU_DR: return tms ? EX2_DR : PAU_DR;
            EX2_DR: return tms ? UPD_DR : SH_DR;
            UPD_DR: return tms ? SEL_DR : RTI;
            SEL_IR: return tms ? TLR    : CAP_IR;
            CAP_IR: return tms ? EX1_IR : SH_IR;
            SH_IR:  return tms ? EX1_IR : SH_IR;
            EX1_IR: return tms ? UPD_IR : PAU_IR;
            PAU_IR: return tms ? EX2_IR : PAU_IR;
            EX2_IR: return tms ? UPD_IR : SH_IR;
            default: return tms ? SEL_DR : RTI;
        endcase
    endfunction

    always @(posedge io_jtag_tck) begin
        tms_log.push_back(io_jtag_tms);
        case (tap)
            TLR: begin
                ir       <= IR_IDCODE;
                user_q   <= 32'h3;
                tlr_hits <= tlr_hits + 1;
            end
            CAP_DR: begin
                dr_sr     <= (ir == IR_IDCODE) ? IDCODE_VAL : (ir == IR_USER) ? user_q : 32'h0;
                shift_in  <= '0;
                shift_cnt <= 0;
            end
            SH_DR: begin
                dr_sr     <= {io_jtag_tdi, dr_sr[31:1]};
                shift_in  <= {io_jtag_tdi, shift_in[31:1]};
                shift_cnt <= shift_cnt + 1;
            end
            UPD_DR: if (ir == IR_USER) user_q <= dr_sr;
            CAP_IR: begin
                ir_sr     <= 4'b0101;
                shift_in  <= '0;
                shift_cnt <= 0;
            end
            SH_IR: begin
                ir_sr     <= {io_jtag_tdi, ir_sr[3:1]};
                shift_in  <= {io_jtag_tdi, shift_in[31:1]};
                shift_cnt <= shift_cnt + 1;
            end
            UPD_IR: ir <= ir_sr;
            default: ;
        endcase
        tap <= tap_next(tap, io_jtag_tms);
    end

    always @(negedge io_jtag_tck) begin
        tdo_r <= (tap == SH_DR) ? dr_sr[0] : (tap == SH_IR) ? ir_sr[0] : 1'b0;
    end

    // ---------------- helpers ----------------
    function automatic logic [63:0] tms_since(input int base);
        logic [63:0] v;
        v = '0;
        for (int i = base; i < tms_log.size() && (i - base) < 64; i++) v[i - base] = tms_log[i];
        return v;
    endfunction

    // Offers a command from a falling edge; returns on the falling edge after acceptance.
    task automatic send_cmd(input logic is_ir, input logic [4:0] len, input logic [31:0] data);
        int guard;
        guard = 0;
        io_cmd_valid  = 1'b1;
        io_cmd_isIr   = is_ir;
        io_cmd_length = len;
        io_cmd_data   = data;
        while (!io_cmd_ready && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        io_cmd_valid = 1'b0;
    endtask

    // Counts cycles from acceptance to rsp_valid; -1 if the response never arrives.
    task automatic wait_rsp(output logic [31:0] rsp, output int lat);
        lat = 1;
        while (!io_rsp_valid && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        if (!io_rsp_valid) lat = -1;
        rsp = io_rsp_data;
    endtask

    // Waits for ready after reset release, watching for stray responses.
    task automatic wait_ready(output int n, output bit saw_valid);
        n = 0;
        saw_valid = 1'b0;
        while (!io_cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
            if (io_rsp_valid) saw_valid = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        int base;
        bit saw_valid;
        io_reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({io_jtag_tck, io_jtag_tms, io_jtag_tdi, io_cmd_ready, io_rsp_valid} !== 5'b01000)
            $display("FAIL reset_pins: got %b want 01000",
                     {io_jtag_tck, io_jtag_tms, io_jtag_tdi, io_cmd_ready, io_rsp_valid});
        else n_pass++;
        n_checks++;
        if (io_rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h want 0", io_rsp_data);
        else n_pass++;
        base = tms_log.size();
        io_reset = 1'b0;
        wait_ready(n, saw_valid);
        n_checks++;
        if (n !== 24) $display("FAIL reset_ready_cycle: got %0d want 24", n);
        else n_pass++;
        n_checks++;
        if (tms_log.size() - base !== 6 || tms_since(base) !== 64'h1F)
            $display("FAIL tlr_tms: got %0d bits %h want 6 bits 1f", tms_log.size() - base, tms_since(base));
        else n_pass++;
        repeat (6) @(negedge clk);
        n_checks++;
        if ({io_jtag_tck, io_cmd_ready, io_jtag_tms} !== 3'b010)
            $display("FAIL idle_pins: got %b want 010", {io_jtag_tck, io_cmd_ready, io_jtag_tms});
        else n_pass++;
        n_checks++;
        if (tap !== RTI) $display("FAIL reset_tap_state: got %0d want %0d", tap, RTI);
        else n_pass++;
    endtask

    task automatic test_dr_idcode();
        logic [31:0] rsp;
        int lat;
        int base;
        base = tms_log.size();
        send_cmd(1'b0, 5'd31, 32'hDEADBEEF);
        wait_rsp(rsp, lat);
        n_checks++;
        if (rsp !== IDCODE_VAL) $display("FAIL dr_idcode_rsp: got %h want %h", rsp, IDCODE_VAL);
        else n_pass++;
        n_checks++;
        if (lat !== 148) $display("FAIL dr_idcode_latency: got %0d want 148", lat);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (shift_in !== 32'hDEADBEEF || shift_cnt !== 32)
            $display("FAIL dr_idcode_tdi: got %h/%0d want deadbeef/32", shift_in, shift_cnt);
        else n_pass++;
        n_checks++;
        if (tap !== RTI || tms_log.size() - base !== 37)
            $display("FAIL dr_idcode_end: got state %0d periods %0d want %0d 37", tap, tms_log.size() - base, RTI);
        else n_pass++;
    endtask

    task automatic test_ir_scan();
        logic [31:0] rsp;
        int lat;
        int base;
        base = tms_log.size();
        send_cmd(1'b1, 5'd3, 32'h2);
        wait_rsp(rsp, lat);
        n_checks++;
        if (rsp !== 32'h5) $display("FAIL ir_rsp: got %h want 00000005", rsp);
        else n_pass++;
        n_checks++;
        if (lat !== 40) $display("FAIL ir_latency: got %0d want 40", lat);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (tms_log.size() - base !== 10 || tms_since(base) !== 64'h183)
            $display("FAIL ir_tms: got %0d bits %h want 10 bits 183", tms_log.size() - base, tms_since(base));
        else n_pass++;
        n_checks++;
        if (shift_in[31:28] !== 4'h2 || shift_cnt !== 4 || ir !== IR_USER)
            $display("FAIL ir_tdi: got %h/%0d ir %h want 2/4 ir 2", shift_in[31:28], shift_cnt, ir);
        else n_pass++;
    endtask

    task automatic test_single_bit();
        logic [31:0] rsp;
        int lat;
        int base;
        base = tms_log.size();
        send_cmd(1'b0, 5'd0, 32'h1);
        wait_rsp(rsp, lat);
        n_checks++;
        if (rsp !== 32'h1) $display("FAIL one_bit_rsp: got %h want 00000001", rsp);
        else n_pass++;
        n_checks++;
        if (lat !== 24) $display("FAIL one_bit_latency: got %0d want 24", lat);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (tms_log.size() - base !== 6 || tms_since(base) !== 64'h19 || shift_cnt !== 1)
            $display("FAIL one_bit_tms: got %0d bits %h shifts %0d want 6 bits 19 shifts 1",
                     tms_log.size() - base, tms_since(base), shift_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rsp;
        int lat;
        send_cmd(1'b0, 5'd31, 32'h12345678);
        wait_rsp(rsp, lat);
        n_checks++;
        if (rsp !== 32'h80000001 || lat !== 148)
            $display("FAIL b2b_first: got %h/%0d want 80000001/148", rsp, lat);
        else n_pass++;
        n_checks++;
        if (io_cmd_ready !== 1'b1) $display("FAIL b2b_ready_in_rsp: got %b want 1", io_cmd_ready);
        else n_pass++;
        send_cmd(1'b0, 5'd31, 32'hCAFEF00D);
        n_checks++;
        if ({io_jtag_tck, io_jtag_tms, io_cmd_ready} !== 3'b010 || io_rsp_data !== 32'h0)
            $display("FAIL b2b_start: got tck/tms/ready %b rsp %h want 010 rsp 0",
                     {io_jtag_tck, io_jtag_tms, io_cmd_ready}, io_rsp_data);
        else n_pass++;
        wait_rsp(rsp, lat);
        n_checks++;
        if (rsp !== 32'h12345678 || lat !== 148)
            $display("FAIL b2b_second: got %h/%0d want 12345678/148", rsp, lat);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] rsp;
        int lat;
        int n;
        int base;
        int hits;
        bit saw_valid;
        send_cmd(1'b0, 5'd31, 32'hFFFF0000);
        repeat (54) @(negedge clk);
        n_checks++;
        if (tap !== SH_DR || shift_cnt !== 11)
            $display("FAIL mid_shift_position: got state %0d shifts %0d want %0d 11", tap, shift_cnt, SH_DR);
        else n_pass++;
        io_reset = 1'b1;
        base = tms_log.size();
        hits = tlr_hits;
        @(negedge clk);
        n_checks++;
        if ({io_jtag_tck, io_jtag_tms, io_jtag_tdi, io_cmd_ready, io_rsp_valid} !== 5'b01000
            || io_rsp_data !== 32'h0)
            $display("FAIL mid_reset_pins: got %b rsp %h want 01000 rsp 0",
                     {io_jtag_tck, io_jtag_tms, io_jtag_tdi, io_cmd_ready, io_rsp_valid}, io_rsp_data);
        else n_pass++;
        io_reset = 1'b0;
        wait_ready(n, saw_valid);
        n_checks++;
        if (n !== 24 || saw_valid !== 1'b0)
            $display("FAIL mid_reset_ready: got %0d stray %b want 24 stray 0", n, saw_valid);
        else n_pass++;
        n_checks++;
        if (tms_log.size() - base !== 6 || tms_since(base) !== 64'h1F)
            $display("FAIL mid_reset_tms: got %0d bits %h want 6 bits 1f", tms_log.size() - base, tms_since(base));
        else n_pass++;
        n_checks++;
        if (tlr_hits <= hits || tap !== RTI)
            $display("FAIL mid_reset_tap: got tlr %0d state %0d want tlr visited state %0d", tlr_hits - hits, tap, RTI);
        else n_pass++;
        send_cmd(1'b0, 5'd31, 32'h0);
        wait_rsp(rsp, lat);
        n_checks++;
        if (rsp !== IDCODE_VAL || lat !== 148)
            $display("FAIL after_reset_scan: got %h/%0d want %h/148", rsp, lat, IDCODE_VAL);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_dr_idcode();
        test_ir_scan();
        test_single_bit();
        test_back_to_back();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
